// File: rtl/fuzz_vector_sequencer.sv
// Differential-simulation run controller: drives LFSR-derived vectors to a ref/dut
// pair of netlists, compares their outputs after a settle delay and accumulates results.
module fuzz_vector_sequencer #(
    parameter int IN_W       = 84,
    parameter int OUT_W      = 119,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed_i,
    input  logic [CNT_W-1:0] num_vec_i,
    output logic [IN_W-1:0]  stim_o,
    input  logic [OUT_W-1:0] y_ref_i,
    input  logic [OUT_W-1:0] y_dut_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [CNT_W-1:0] vec_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COMPARE,
        DONE
    } state_t;

    localparam logic [7:0]  SETTLE_INIT = 8'(SETTLE_CYC - 1);
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;

    state_t           state, state_nxt;
    logic [31:0]      lfsr, lfsr_nxt, lfsr_adv;
    logic [7:0]       settle_cnt, settle_cnt_nxt;
    logic [CNT_W-1:0] num_vec, num_vec_nxt;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W-1:0] vec_idx_nxt, mismatch_cnt_nxt, first_fail_idx_nxt;
    logic             first_fail_valid_nxt, done_nxt, pass_nxt;
    logic [IN_W-1:0]  stim_nxt, stim_rep;

    assign busy     = (state == SETTLE) || (state == COMPARE);
    assign last_idx = num_vec - CNT_W'(1);

    // Galois step; the new word is tiled from the LSB to fill the whole input bus.
    always_comb begin
        lfsr_adv = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        for (int i = 0; i < IN_W; i++) begin
            stim_rep[i] = lfsr_adv[i[4:0]];
        end
    end

    always_comb begin
        // NOTE: every next-value starts as a copy of its register so no path through the case leaves it unassigned, which would infer a latch.
        state_nxt            = state;
        lfsr_nxt             = lfsr;
        settle_cnt_nxt       = settle_cnt;
        num_vec_nxt          = num_vec;
        vec_idx_nxt          = vec_idx;
        mismatch_cnt_nxt     = mismatch_cnt;
        first_fail_valid_nxt = first_fail_valid;
        first_fail_idx_nxt   = first_fail_idx;
        done_nxt             = done;
        pass_nxt             = pass;
        stim_nxt             = stim_o;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stim_nxt             = '0;
                    lfsr_nxt             = (seed_i == 32'd0) ? 32'd1 : seed_i;
                    vec_idx_nxt          = '0;
                    mismatch_cnt_nxt     = '0;
                    first_fail_valid_nxt = 1'b0;
                    first_fail_idx_nxt   = '0;
                    num_vec_nxt          = num_vec_i;
                    if (num_vec_i == '0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b1;
                    end else begin
                        state_nxt      = SETTLE;
                        done_nxt       = 1'b0;
                        pass_nxt       = 1'b0;
                        settle_cnt_nxt = SETTLE_INIT;
                    end
                end
            end

            SETTLE: begin
                if (settle_cnt == 8'd0) begin
                    state_nxt = COMPARE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 8'd1;
                end
            end

            COMPARE: begin
                if (y_ref_i != y_dut_i) begin
                    if (!(&mismatch_cnt)) begin
                        mismatch_cnt_nxt = mismatch_cnt + CNT_W'(1);
                    end
                    if (!first_fail_valid) begin
                        first_fail_valid_nxt = 1'b1;
                        first_fail_idx_nxt   = vec_idx;
                    end
                end
                if (vec_idx == last_idx) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = (mismatch_cnt_nxt == '0);
                end else begin
                    lfsr_nxt       = lfsr_adv;
                    stim_nxt       = stim_rep;
                    vec_idx_nxt    = vec_idx + CNT_W'(1);
                    settle_cnt_nxt = SETTLE_INIT;
                    state_nxt      = SETTLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // Reset discards a run in flight entirely; nothing partial survives.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all of them update together from pre-edge values.
        if (!rst_n) begin
            state            <= IDLE;
            lfsr             <= '0;
            settle_cnt       <= '0;
            num_vec          <= '0;
            vec_idx          <= '0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            done             <= 1'b0;
            pass             <= 1'b0;
            stim_o           <= '0;
        end else begin
            state            <= state_nxt;
            lfsr             <= lfsr_nxt;
            settle_cnt       <= settle_cnt_nxt;
            num_vec          <= num_vec_nxt;
            vec_idx          <= vec_idx_nxt;
            mismatch_cnt     <= mismatch_cnt_nxt;
            first_fail_valid <= first_fail_valid_nxt;
            first_fail_idx   <= first_fail_idx_nxt;
            done             <= done_nxt;
            pass             <= pass_nxt;
            stim_o           <= stim_nxt;
        end
    end

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Randomized self-checking bench for fuzz_vector_sequencer against a cycle-count
// and LFSR-sequence reference model.
module tb_fuzz_vector_sequencer;

    localparam int IN_W       = 84;
    localparam int OUT_W      = 119;
    localparam int SETTLE_CYC = 1;
    localparam int CNT_W      = 16;
    localparam int VPC        = SETTLE_CYC + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [31:0]      seed_i;
    logic [CNT_W-1:0] num_vec_i;
    logic [IN_W-1:0]  stim_o;
    logic [OUT_W-1:0] y_ref_i;
    logic [OUT_W-1:0] y_dut_i;
    logic             busy, done, pass, first_fail_valid;
    logic [CNT_W-1:0] mismatch_cnt, first_fail_idx, vec_idx;

    int n_tests = 0;
    int n_fail  = 0;

    bit          flip_en  [0:63];
    int          flip_bit [0:63];
    logic [31:0] lows[$];

    fuzz_vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_i(seed_i),
        .num_vec_i(num_vec_i), .stim_o(stim_o), .y_ref_i(y_ref_i),
        .y_dut_i(y_dut_i), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
    );

    always #5 clk = ~clk;

    // Harness fault injection: the dut copy differs only while a flagged vector is applied.
    always_comb begin
        y_dut_i = y_ref_i;
        if (vec_idx < 16'd64 && flip_en[vec_idx[5:0]])
            y_dut_i = y_ref_i ^ (OUT_W'(1) << flip_bit[vec_idx[5:0]]);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] exp_vec(input logic [31:0] seed, input int idx);
        logic [31:0] l;
        logic [95:0] t;
        if (idx == 0) return '0;
        l = (seed == 32'd0) ? 32'd1 : seed;
        for (int n = 0; n < idx; n++)
            l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        t = {l, l, l};
        return t[IN_W-1:0];
    endfunction

    task automatic clear_flips();
        for (int i = 0; i < 64; i++) begin
            flip_en[i]  = 1'b0;
            flip_bit[i] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_mm"}, mismatch_cnt, 0);
        check({tag, "_ffv"}, first_fail_valid, 0);
        check({tag, "_ffi"}, first_fail_idx, 0);
        check({tag, "_idx"}, vec_idx, 0);
        check({tag, "_stim"}, stim_o, 0);
    endtask

    // One run: k counts edges after the one that samples start.
    task automatic run(input logic [31:0] seed, input int num, input bit ign, input bit rst_mid);
        logic [127:0] r;
        int  lat, k, exp_idx, exp_mm, exp_first;
        bit  seen;
        r       = {$urandom, $urandom, $urandom, $urandom};
        y_ref_i = r[OUT_W-1:0];
        exp_mm = 0; exp_first = 0; seen = 0;
        for (int i = 0; i < num; i++) begin
            if (flip_en[i]) begin
                exp_mm++;
                if (!seen) begin exp_first = i; seen = 1; end
            end
        end
        lat = num * VPC;
        lows.delete();

        @(negedge clk);
        seed_i = seed; num_vec_i = CNT_W'(num); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; seed_i = $urandom; num_vec_i = CNT_W'($urandom);
        k = 0;
        forever begin
            exp_idx = (k < lat) ? k / VPC : ((num > 0) ? num - 1 : 0);
            check("busy", busy, (k < lat) ? 1 : 0);
            check("done", done, (k >= lat) ? 1 : 0);
            check("vec_idx", vec_idx, exp_idx);
            check("stim", stim_o, exp_vec(seed, exp_idx));
            if (k < lat && k % VPC == 0) lows.push_back(stim_o[31:0]);
            if (k >= lat) break;
            if (rst_mid && k == 5 * VPC) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_zero("midrst");
                return;
            end
            if (ign && (k == 4 || k == 9)) begin
                start = 1'b1; seed_i = $urandom; num_vec_i = CNT_W'($urandom_range(1, 50));
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
        end
        check("pass", pass, (exp_mm == 0) ? 1 : 0);
        check("mismatch_cnt", mismatch_cnt, exp_mm);
        check("ff_valid", first_fail_valid, (exp_mm > 0) ? 1 : 0);
        check("ff_idx", first_fail_idx, exp_first);
    endtask

    initial begin
        int num;
        logic [31:0] rseed;
        clear_flips();
        start = 1'b0; seed_i = '0; num_vec_i = '0; y_ref_i = '0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        run(32'd1, 21, 0, 0);
        check("seed1_v0", lows[0], 32'h0);
        check("seed1_v1", lows[1], 32'h8020_0003);

        flip_en[3] = 1'b1; flip_en[7] = 1'b1;
        run($urandom, 10, 0, 0);
        clear_flips();

        run($urandom, 0, 0, 0);

        run(32'd0, 2, 0, 0);
        check("seed0_v1", lows[1], 32'h8020_0003);

        run(32'hDEAD_BEEF, 21, 1, 0);

        rseed = $urandom;
        run(rseed, 21, 0, 1);
        run(rseed, 21, 0, 0);

        for (int r = 0; r < 8; r++) begin
            clear_flips();
            num = $urandom_range(1, 40);
            for (int i = 0; i < num; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    flip_en[i]  = 1'b1;
                    flip_bit[i] = $urandom_range(0, OUT_W - 1);
                end
            end
            run($urandom, num, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
